// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with double-buffered value,
// anti-ghost blanking gap and optional leading-zero suppression.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   value[15:0]       four hex nibbles, digit 0 = value[3:0]
//   load              strobe: capture value into the pending buffer
//   lz_blank          1 = suppress leading zero digits
//   w, x, y, z        nibble of the digit being scanned (w = MSB)
//   an[3:0]           active-low digit enables
//   frame_done        pulse in the last cycle of the digit-3 slot
//   pending           a loaded value awaits the next frame boundary
module seg_scan_controller #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_GAP   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pbuf_q, pbuf_d;
  logic [15:0]   dreg_q, dreg_d;
  logic          pend_q, pend_d;

  logic [3:0]    an_q, an_d;
  logic [3:0]    nib_q, nib_d;
  logic          fd_q, fd_d;

  logic          wrap;
  logic          bound;
  logic          gap_d;
  logic          blank_d;

  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    bound  = wrap && (idx_q == 2'd3);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    dreg_d = (bound && pend_q) ? pbuf_q : dreg_q;
    pbuf_d = load ? value : pbuf_q;
    pend_d = pend_q;
    if (load) begin
      pend_d = 1'b1;
    end else if (bound) begin
      pend_d = 1'b0;
    end
  end

  // Outputs are precomputed from next state so they leave flops
  // aligned with the state they describe.
  always_comb begin
    nib_d   = 4'h0;
    blank_d = 1'b0;
    unique case (1'b1)
      idx_d == 2'd0: begin
        nib_d   = dreg_d[3:0];
        blank_d = 1'b0;
      end
      idx_d == 2'd1: begin
        nib_d   = dreg_d[7:4];
        blank_d = lz_blank && (dreg_d[15:4] == 12'h0);
      end
      idx_d == 2'd2: begin
        nib_d   = dreg_d[11:8];
        blank_d = lz_blank && (dreg_d[15:8] == 8'h0);
      end
      default: begin
        nib_d   = dreg_d[15:12];
        blank_d = lz_blank && (dreg_d[15:12] == 4'h0);
      end
    endcase
    gap_d = (32'(cnt_d) < BLANK_GAP);
    an_d  = (gap_d || blank_d) ? 4'hF : ~(4'b0001 << idx_d);
    fd_d  = (idx_d == 2'd3) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      pbuf_q <= 16'h0;
      dreg_q <= 16'h0;
      pend_q <= 1'b0;
      an_q   <= 4'hF;
      nib_q  <= 4'h0;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pbuf_q <= pbuf_d;
      dreg_q <= dreg_d;
      pend_q <= pend_d;
      an_q   <= an_d;
      nib_q  <= nib_d;
      fd_q   <= fd_d;
    end
  end

  assign w          = nib_q[3];
  assign x          = nib_q[2];
  assign y          = nib_q[1];
  assign z          = nib_q[0];
  assign an         = an_q;
  assign frame_done = fd_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller against a cycle-count
// reference model of the scan, buffering and blanking rules.
module tb_seg_scan_controller;

  localparam int RD    = 8;
  localparam int BG    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic        w, x, y, z;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;

  int          mt;
  logic [15:0] m_disp, m_pbuf;
  logic        m_pend;
  logic [9:0]  exp_v;
  logic [9:0]  obs;

  seg_scan_controller #(
    .REFRESH_DIV(RD),
    .BLANK_GAP(BG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .load(load),
    .lz_blank(lz_blank),
    .w(w),
    .x(x),
    .y(y),
    .z(z),
    .an(an),
    .frame_done(frame_done),
    .pending(pending)
  );

  always #5 clk = ~clk;

  assign obs = {an, w, x, y, z, frame_done, pending};

  task automatic step(input logic r, input logic l,
                      input logic [15:0] v, input logic lzb);
    logic        bnd;
    int          dig;
    int          pos;
    logic [15:0] hi;
    logic        blk;
    logic [3:0]  e_an;
    reset = r;
    load = l;
    value = v;
    lz_blank = lzb;
    @(posedge clk);
    if (r) begin
      mt = 0;
      m_disp = 16'h0;
      m_pbuf = 16'h0;
      m_pend = 1'b0;
    end else begin
      bnd = (mt % FRAME) == FRAME - 1;
      if (bnd && m_pend) m_disp = m_pbuf;
      if (l) begin
        m_pbuf = v;
        m_pend = 1'b1;
      end else if (bnd) begin
        m_pend = 1'b0;
      end
      mt++;
    end
    dig = (mt / RD) % 4;
    pos = mt % RD;
    hi = m_disp >> (4 * dig);
    blk = lzb && (dig != 0) && (hi == 16'h0);
    e_an = (pos < BG || blk) ? 4'hF : ~(4'b0001 << dig);
    exp_v = {e_an, hi[3:0], ((mt % FRAME) == FRAME - 1), m_pend};
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'hFFFF, 1'b0);
      checks++;
      if (obs !== 10'b1111_0000_0_0) begin
        errors++;
        $display("FAIL reset_hold got=%b want=%b", obs, 10'b1111000000);
      end
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_slot t=%0d got=%b want=%b", mt, obs, exp_v);
      end
    end
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL reset_cycle8_an got=%b want=1111", an);
    end
  endtask

  task automatic test_load_transfer;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    while (mt < 5) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    while (mt < 2 * FRAME) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL load_xfer t=%0d got=%b want=%b", mt, obs, exp_v);
      end
      if (mt == 6 || mt == 32 || mt == 42 || mt == 50 || mt == 58) begin
        checks++;
        if ((mt == 6 && pending !== 1'b1) ||
            (mt == 32 && ({w, x, y, z} !== 4'h4 || pending !== 1'b0)) ||
            (mt == 42 && ({w, x, y, z} !== 4'h3 || an !== 4'b1101)) ||
            (mt == 50 && ({w, x, y, z} !== 4'h2 || an !== 4'b1011)) ||
            (mt == 58 && ({w, x, y, z} !== 4'h1 || an !== 4'b0111))) begin
          errors++;
          $display("FAIL load_point t=%0d got an=%b nib=%h pend=%b",
                   mt, an, {w, x, y, z}, pending);
        end
      end
    end
  endtask

  task automatic test_lz_blank;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0050, 1'b1);
    while (mt < 2 * FRAME) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL lz_0050 t=%0d got=%b want=%b", mt, obs, exp_v);
      end
      if (mt >= 48) begin
        checks++;
        if (an !== 4'hF) begin
          errors++;
          $display("FAIL lz_hi_dark t=%0d got an=%b want=1111", mt, an);
        end
      end
    end
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    while (mt < 4 * FRAME) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL lz_0000 t=%0d got=%b want=%b", mt, obs, exp_v);
      end
      if (mt >= 3 * FRAME) begin
        checks++;
        if (an !== (((mt % RD) >= BG && mt < 3 * FRAME + RD) ? 4'hE : 4'hF)) begin
          errors++;
          $display("FAIL lz_only_d0 t=%0d got an=%b", mt, an);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    while (mt < 10) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 1'b1, 16'hBBBB, 1'b0);
    while (mt < 70) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b t=%0d got=%b want=%b", mt, obs, exp_v);
      end
      if (mt >= 32 && mt < 64) begin
        checks++;
        if ({w, x, y, z} !== 4'hB) begin
          errors++;
          $display("FAIL b2b_last_wins t=%0d got=%h want=b", mt, {w, x, y, z});
        end
      end
    end
    step(1'b0, 1'b1, 16'hDDDD, 1'b0);
    while (mt < 3 * FRAME - 1) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'hCCCC, 1'b0);
    while (mt < 5 * FRAME) begin
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL collide t=%0d got=%b want=%b", mt, obs, exp_v);
      end
      if (mt >= 3 * FRAME && mt < 4 * FRAME) begin
        checks++;
        if ({w, x, y, z} !== 4'hD || pending !== 1'b1) begin
          errors++;
          $display("FAIL collide_old t=%0d got nib=%h pend=%b want d/1",
                   mt, {w, x, y, z}, pending);
        end
      end
      if (mt >= 4 * FRAME) begin
        checks++;
        if ({w, x, y, z} !== 4'hC || pending !== 1'b0) begin
          errors++;
          $display("FAIL collide_new t=%0d got nib=%h pend=%b want c/0",
                   mt, {w, x, y, z}, pending);
        end
      end
      step(1'b0, 1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1111, 1'b0);
    while (mt < FRAME) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h5678, 1'b0);
    while (mt != FRAME + 2 * RD + 4) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (an !== 4'hF || pending !== 1'b0 || {w, x, y, z} !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid got an=%b pend=%b nib=%h want 1111/0/0",
               an, pending, {w, x, y, z});
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_after t=%0d got=%b want=%b", mt, obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap;
    int fd_n;
    fd_n = 0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h9E07, 1'b0);
    while (mt < FRAME) step(1'b0, 1'b0, 16'h0, 1'b0);
    while (mt < 4 * FRAME) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL wrap t=%0d got=%b want=%b", mt, obs, exp_v);
      end
      if (frame_done) fd_n++;
    end
    checks++;
    if (fd_n != 3) begin
      errors++;
      $display("FAIL wrap_fd_count got=%0d want=3", fd_n);
    end
  endtask

  task automatic test_random;
    logic lzr;
    lzr = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) lzr = ~lzr;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
           16'($urandom), lzr);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random t=%0d got=%b want=%b", mt, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_transfer();
    test_lz_blank();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
